// File: rtl/event_generation.sv
// Forwarded IO clock generator: builds a programmable-rate clock on a
// pos/neg pin pair from the system clock, either free-running or as a burst
// of N cycles. It never truncates a pulse when it stops, and it emits one-cycle
// strobes aligned with the pin transitions so that transmit data can launch
// on them.

package common_p;
    typedef struct packed {
        logic clk;
        logic rst;
    } clk_dom;
endpackage

package clks_alot_p;
    typedef struct packed {
        logic pos;
        logic neg;
    } recovery_pins_s;
endpackage

module event_generation #(
    parameter int HALF_W = 8,
    parameter int CNT_W  = 16
) (
    input  common_p::clk_dom            sys_dom_i,
    input  logic                        generation_en_i,
    input  logic                        polarity_select_i,
    input  logic                        diff_mode_i,
    input  logic                        idle_level_i,
    input  logic [HALF_W-1:0]           half_period_i,
    input  logic [CNT_W-1:0]            cycle_limit_i,
    output clks_alot_p::recovery_pins_s io_clk_o,
    output logic                        leading_edge_o,
    output logic                        trailing_edge_o,
    output logic                        active_o,
    output logic                        done_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    logic clk;
    logic rst;
    assign clk = sys_dom_i.clk;
    assign rst = sys_dom_i.rst;

    state_e                      state_q, state_d;
    logic                        prim_q, prim_d;
    logic [HALF_W-1:0]           half_cnt_q, half_cnt_d;
    logic [CNT_W-1:0]            cyc_cnt_q, cyc_cnt_d;
    logic                        pol_q, pol_d;
    logic                        diff_q, diff_d;
    logic                        idle_q, idle_d;
    logic [HALF_W-1:0]           half_q, half_d;
    logic [CNT_W-1:0]            limit_q, limit_d;
    clks_alot_p::recovery_pins_s pins_q, pins_d;
    logic                        lead_q, lead_d;
    logic                        trail_q, trail_d;
    logic                        active_q, active_d;
    logic                        done_q, done_d;
    logic [CNT_W-1:0]            cyc_next;

    // Primary/secondary to pos/neg mapping; secondary is ~primary only in differential mode.
    function automatic clks_alot_p::recovery_pins_s map_pins(input logic prim,
                                                             input logic diff,
                                                             input logic pol);
        logic                        sec;
        clks_alot_p::recovery_pins_s p;
        sec   = diff ? ~prim : 1'b0;
        p.pos = pol ? prim : sec;
        p.neg = pol ? sec : prim;
        return p;
    endfunction

    // Next-state logic: IDLE tracks the live inputs as the config-to-be, RUN/DONE hold the latched copy.
    always_comb begin
        state_d    = state_q;
        prim_d     = prim_q;
        half_cnt_d = half_cnt_q;
        cyc_cnt_d  = cyc_cnt_q;
        pol_d      = pol_q;
        diff_d     = diff_q;
        idle_d     = idle_q;
        half_d     = half_q;
        limit_d    = limit_q;
        lead_d     = 1'b0;
        trail_d    = 1'b0;
        done_d     = 1'b0;
        active_d   = active_q;
        cyc_next   = (cyc_cnt_q == {CNT_W{1'b1}}) ? cyc_cnt_q : cyc_cnt_q + CNT_W'(1);

        case (state_q)
            ST_IDLE: begin
                pol_d   = polarity_select_i;
                diff_d  = diff_mode_i;
                idle_d  = idle_level_i;
                half_d  = half_period_i;
                limit_d = cycle_limit_i;
                prim_d  = idle_level_i;
                if (generation_en_i) begin
                    state_d    = ST_RUN;
                    prim_d     = ~idle_level_i;
                    lead_d     = 1'b1;
                    active_d   = 1'b1;
                    half_cnt_d = '0;
                    cyc_cnt_d  = '0;
                end
            end
            ST_RUN: begin
                if (half_cnt_q == half_q) begin
                    half_cnt_d = '0;
                    if (prim_q != idle_q) begin
                        // End of the active phase: always completes, enable is ignored here.
                        prim_d    = idle_q;
                        trail_d   = 1'b1;
                        cyc_cnt_d = cyc_next;
                        if ((limit_q != '0) && (cyc_next == limit_q)) begin
                            done_d   = 1'b1;
                            state_d  = ST_DONE;
                            active_d = 1'b0;
                        end
                    end else if (!generation_en_i) begin
                        // Stop only where a new pulse would begin; pin is already idle.
                        state_d  = ST_IDLE;
                        active_d = 1'b0;
                    end else begin
                        prim_d = ~idle_q;
                        lead_d = 1'b1;
                    end
                end else begin
                    half_cnt_d = half_cnt_q + HALF_W'(1);
                end
            end
            ST_DONE: begin
                prim_d = idle_q;
                if (!generation_en_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                active_d = 1'b0;
            end
        endcase

        pins_d = map_pins(prim_d, diff_d, pol_d);
    end

    // State, config and registered outputs; reset parks everything at zero immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            prim_q     <= 1'b0;
            half_cnt_q <= '0;
            cyc_cnt_q  <= '0;
            pol_q      <= 1'b0;
            diff_q     <= 1'b0;
            idle_q     <= 1'b0;
            half_q     <= '0;
            limit_q    <= '0;
            pins_q     <= '0;
            lead_q     <= 1'b0;
            trail_q    <= 1'b0;
            active_q   <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            prim_q     <= prim_d;
            half_cnt_q <= half_cnt_d;
            cyc_cnt_q  <= cyc_cnt_d;
            pol_q      <= pol_d;
            diff_q     <= diff_d;
            idle_q     <= idle_d;
            half_q     <= half_d;
            limit_q    <= limit_d;
            pins_q     <= pins_d;
            lead_q     <= lead_d;
            trail_q    <= trail_d;
            active_q   <= active_d;
            done_q     <= done_d;
        end
    end

    assign io_clk_o        = pins_q;
    assign leading_edge_o  = lead_q;
    assign trailing_edge_o = trail_q;
    assign active_o        = active_q;
    assign done_o          = done_q;

endmodule
